// File: rtl/nios_debug_scan_master.sv
// Virtual-JTAG scan master: takes one IR/DR command, walks the
// UIR -> CDR -> SDR -> UDR -> RTI sequence with a divided tck, and returns
// the DR bits captured from vji_tdo. UIR is skipped when the slave already
// holds the requested IR value.
module nios_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic [1:0]          vji_ir_in,
    input  logic                vji_tdo
);

    localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE, UIR, CDR, SDR, UDR, RTI, RESP
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                phase_q;     // 0 = tck low half, 1 = tck high half
    logic [BIT_W-1:0]    bit_q;
    logic [DR_WIDTH-1:0] sr_q;        // shifts out toward tdi, fills from tdo at the top
    logic [DR_WIDTH-1:0] sr_d;
    logic                ir_valid_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DR_WIDTH-1:0] rsp_data_q;
    logic                tck_q, tdi_q, rti_q, uir_q, cdr_q, sdr_q, udr_q;
    logic [1:0]          ir_in_q;

    logic half_end;
    logic period_end;

    assign half_end   = (cnt_q == CNT_W'(TCK_DIV - 1));
    assign period_end = half_end && phase_q;

    // Next shift-register value: one bit out at the bottom, tdo captured at the top.
    generate
        if (DR_WIDTH > 1) begin : g_sr
            assign sr_d = {vji_tdo, sr_q[DR_WIDTH-1:1]};
        end else begin : g_sr1
            assign sr_d = vji_tdo;
        end
    endgenerate

    // Scan sequencer: state, tck divider, shift path and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            bit_q       <= '0;
            ir_valid_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            rti_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            ir_in_q     <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        sr_q        <= cmd_data;
                        cnt_q       <= '0;
                        phase_q     <= 1'b0;
                        tck_q       <= 1'b0;
                        bit_q       <= '0;
                        if (ir_valid_q && (cmd_ir == ir_in_q)) begin
                            state_q <= CDR;
                            cdr_q   <= 1'b1;
                        end else begin
                            state_q <= UIR;
                            uir_q   <= 1'b1;
                            ir_in_q <= cmd_ir;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    // Divider runs back-to-back; tck mirrors the phase bit.
                    if (half_end) begin
                        cnt_q   <= '0;
                        phase_q <= ~phase_q;
                        tck_q   <= ~phase_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (period_end) begin
                        case (state_q)
                            UIR: begin
                                state_q    <= CDR;
                                uir_q      <= 1'b0;
                                cdr_q      <= 1'b1;
                                ir_valid_q <= 1'b1;
                            end
                            CDR: begin
                                state_q <= SDR;
                                cdr_q   <= 1'b0;
                                sdr_q   <= 1'b1;
                                tdi_q   <= sr_q[0];
                            end
                            SDR: begin
                                sr_q <= sr_d;
                                if (bit_q == BIT_W'(DR_WIDTH - 1)) begin
                                    state_q <= UDR;
                                    sdr_q   <= 1'b0;
                                    udr_q   <= 1'b1;
                                    tdi_q   <= 1'b0;
                                end else begin
                                    bit_q <= bit_q + BIT_W'(1);
                                    tdi_q <= sr_d[0];
                                end
                            end
                            UDR: begin
                                state_q <= RTI;
                                udr_q   <= 1'b0;
                                rti_q   <= 1'b1;
                            end
                            RTI: begin
                                state_q     <= RESP;
                                rti_q       <= 1'b0;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= sr_q;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_rti   = rti_q;
    assign vji_uir   = uir_q;
    assign vji_cdr   = cdr_q;
    assign vji_sdr   = sdr_q;
    assign vji_udr   = udr_q;
    assign vji_ir_in = ir_in_q;

endmodule
